// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares one 512-bit AXI block-transfer port between the instruction cache
// (refill reads) and the data cache (write-backs and refill reads).
// One transaction is granted at a time. The winner's address, and for a
// write-back its victim block, are latched at grant. The AXI start level is
// held for the whole transaction. Completion and refill write enables are
// routed back to the owning cache. A transaction that stays outstanding too
// long is aborted, and a sticky error flag is raised.
//
// Ports
//   clk                 system clock, rising edge
//   arstn               asynchronous active-low reset
//   i_icache_rd_req     I-cache refill request (level, held until done)
//   i_icache_addr       I-cache refill block address
//   i_dcache_rd_req     D-cache refill request (level)
//   i_dcache_wr_req     D-cache write-back request (level)
//   i_dcache_rd_addr    D-cache refill address
//   i_dcache_wr_addr    D-cache victim address
//   i_dcache_wr_data    D-cache victim block
//   i_read_last_axi     final beat of the AXI read burst
//   i_data_read_axi     assembled read block
//   i_b_resp_axi        AXI write response received
//   o_start_read_axi    AXI read start level (high throughout RD)
//   o_start_write_axi   AXI write start level (high throughout WR)
//   o_addr_axi          latched transaction address
//   o_data_write_axi    latched write-back block
//   o_block_data        read block passed through to both caches
//   o_icache_we         I-cache block write enable
//   o_dcache_we         D-cache block write enable
//   o_icache_done       I-cache transaction-complete pulse
//   o_dcache_done       D-cache transaction-complete pulse
//   o_busy              high whenever a transaction is outstanding
//   o_timeout_err       sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   i_icache_rd_req,
  input  logic [ADDR_WIDTH-1:0]  i_icache_addr,
  input  logic                   i_dcache_rd_req,
  input  logic                   i_dcache_wr_req,
  input  logic [ADDR_WIDTH-1:0]  i_dcache_rd_addr,
  input  logic [ADDR_WIDTH-1:0]  i_dcache_wr_addr,
  input  logic [BLOCK_WIDTH-1:0] i_dcache_wr_data,
  input  logic                   i_read_last_axi,
  input  logic [BLOCK_WIDTH-1:0] i_data_read_axi,
  input  logic                   i_b_resp_axi,
  output logic                   o_start_read_axi,
  output logic                   o_start_write_axi,
  output logic [ADDR_WIDTH-1:0]  o_addr_axi,
  output logic [BLOCK_WIDTH-1:0] o_data_write_axi,
  output logic [BLOCK_WIDTH-1:0] o_block_data,
  output logic                   o_icache_we,
  output logic                   o_dcache_we,
  output logic                   o_icache_done,
  output logic                   o_dcache_done,
  output logic                   o_busy,
  output logic                   o_timeout_err
);

  localparam int CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   ownerD_q, ownerD_d;
  logic                   prefD_q, prefD_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic iReq;
  logic dReq;
  logic grantI;
  logic grantD;
  logic finish;
  logic finishWe;

  // State register and transaction latches.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      ownerD_q <= 1'b0;
      prefD_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ownerD_q <= ownerD_d;
      prefD_q  <= prefD_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Arbitration between the two caches. The round-robin pointer only
  // matters when both caches are requesting. Otherwise the lone requester
  // wins.
  always_comb begin
    iReq   = i_icache_rd_req;
    dReq   = i_dcache_wr_req | i_dcache_rd_req;
    grantI = iReq & (~dReq | ~prefD_q);
    grantD = dReq & ~grantI;
  end

  // Next-state and output logic. Completion is checked before the timeout
  // so that a last beat arriving in the final allowed cycle still counts as
  // a clean finish.
  always_comb begin
    state_d           = state_q;
    ownerD_d          = ownerD_q;
    prefD_d           = prefD_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    cnt_d             = cnt_q;
    err_d             = err_q;
    finish            = 1'b0;
    finishWe          = 1'b0;
    o_start_read_axi  = 1'b0;
    o_start_write_axi = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grantI) begin
          state_d  = RD;
          ownerD_d = 1'b0;
          prefD_d  = 1'b1;
          addr_d   = i_icache_addr;
          cnt_d    = '0;
        end else if (grantD) begin
          ownerD_d = 1'b1;
          prefD_d  = 1'b0;
          cnt_d    = '0;
          // A dirty victim must leave before its refill can overwrite it.
          if (i_dcache_wr_req) begin
            state_d = WR;
            addr_d  = i_dcache_wr_addr;
            wdata_d = i_dcache_wr_data;
          end else begin
            state_d = RD;
            addr_d  = i_dcache_rd_addr;
          end
        end
      end
      RD: begin
        o_start_read_axi = 1'b1;
        if (i_read_last_axi) begin
          finish   = 1'b1;
          finishWe = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == CntMax) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WR: begin
        o_start_write_axi = 1'b1;
        if (i_b_resp_axi) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CntMax) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_icache_done    = finish & ~ownerD_q;
  assign o_dcache_done    = finish & ownerD_q;
  assign o_icache_we      = finishWe & ~ownerD_q;
  assign o_dcache_we      = finishWe & ownerD_q;
  assign o_addr_axi       = addr_q;
  assign o_data_write_axi = wdata_q;
  assign o_block_data     = i_data_read_axi;
  assign o_busy           = (state_q != IDLE);
  assign o_timeout_err    = err_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single 512-bit AXI block-transfer port between the instruction cache (refill reads) and the data cache (dirty write-backs and refill reads).
- Sits between the caches/control unit and the AXI master.
- Grants one transaction at a time, latches its address and write data, and holds the AXI start level for the whole transaction.
- Returns completion, and routes refill data, to the owning cache; aborts a hung transaction after a timeout.

Parameters:
- ADDR_WIDTH, 64, width of block addresses.
- BLOCK_WIDTH, 512, cache block / AXI burst payload width.
- TIMEOUT_CYCLES, 1024, maximum cycles one transaction may stay outstanding; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
- i_icache_rd_req  in  1  I-cache refill request, level, held until o_icache_done.
- i_icache_addr  in  ADDR_WIDTH  I-cache refill block address.
- i_dcache_rd_req  in  1  D-cache refill request, level.
- i_dcache_wr_req  in  1  D-cache write-back request, level.
- i_dcache_rd_addr  in  ADDR_WIDTH  D-cache refill address.
- i_dcache_wr_addr  in  ADDR_WIDTH  D-cache write-back (victim) address.
- i_dcache_wr_data  in  BLOCK_WIDTH  D-cache victim block.
- i_read_last_axi  in  1  final beat of the AXI read burst; data valid in this cycle.
- i_data_read_axi  in  BLOCK_WIDTH  assembled read block.
- i_b_resp_axi  in  1  AXI write response received.
- o_start_read_axi  out  1  AXI read start.
- o_start_write_axi  out  1  AXI write start.
- o_addr_axi  out  ADDR_WIDTH  latched transaction address.
- o_data_write_axi  out  BLOCK_WIDTH  latched write-back block.
- o_block_data  out  BLOCK_WIDTH  i_data_read_axi passed through to both caches.
- o_icache_we  out  1  I-cache block write enable.
- o_dcache_we  out  1  D-cache block write enable.
- o_icache_done  out  1  I-cache transaction-complete pulse.
- o_dcache_done  out  1  D-cache transaction-complete pulse.
- o_busy  out  1  high whenever state is not IDLE.
- o_timeout_err  out  1  sticky timeout flag.

Behaviour:
- State machine states: IDLE, RD, WR. On reset: state = IDLE, all outputs 0, address/data latches 0, timeout counter 0, round-robin pointer prefers the I-cache.
- Arbitration in IDLE:
  - Requests are sampled at each rising edge.
  - The winner's address (and, for a write, its data) are latched; next cycle state = RD or WR.
  - Within the D-cache, a write-back always beats a refill.
  - Between the I-cache and D-cache: round-robin. Once the I-cache has been granted, the D-cache is preferred next, and vice versa.
  - A request with no competitor is granted regardless of the pointer.
- Start signals:
  - o_start_read_axi is high for every cycle in RD.
  - o_start_write_axi is high for every cycle in WR.
  - Both go low in the cycle after completion.
- Minimum latency: request high at edge N -> start high from cycle N+1.
- RD completion:
  - Occurs in the cycle i_read_last_axi = 1.
  - In that same cycle, the owner's *_we = 1 and the owner's *_done = 1, both combinational.
  - Next state = IDLE.
- WR completion:
  - Occurs in the cycle i_b_resp_axi = 1.
  - o_dcache_done = 1 combinationally; no *_we.
  - Next state = IDLE.
- Requester obligation: deassert the request at the edge where done is seen. A request still high in the following IDLE cycle is treated as a new request.
- Back-to-back grants: at least one IDLE cycle separates transactions.
- Latches:
  - o_addr_axi and o_data_write_axi hold their latched values from grant until the next grant.
  - Input changes during a transaction are ignored.
- o_block_data always equals i_data_read_axi.
- Timeout:
  - The counter clears on entry to RD/WR and increments each cycle spent in RD/WR.
  - If it reaches TIMEOUT_CYCLES-1 without completion, the owner's done pulses with no we, o_timeout_err is set, and state returns to IDLE.
  - o_timeout_err is cleared only by reset.
- Simultaneous completion and timeout in the same cycle: completion wins and the error is not set.
- Completion inputs outside their state (i_read_last_axi outside RD, i_b_resp_axi outside WR) are ignored.
- Reset mid-transaction: immediately returns to IDLE with all outputs 0; no done is issued.

Test Plan:
- Single I-cache refill:
  - Stimulus: i_icache_rd_req=1, addr=0x1000; i_read_last_axi pulsed 5 cycles after start.
  - Required response: start_read high for exactly 5 cycles, o_addr_axi=0x1000, o_icache_we and o_icache_done high in the last-beat cycle, o_busy low the next cycle.
- D-cache write-back before refill:
  - Stimulus: i_dcache_wr_req and i_dcache_rd_req high together, wr_addr=0x2040, rd_addr=0x3080.
  - Required response: WR at 0x2040 completes on i_b_resp_axi; IDLE for one cycle; then RD at 0x3080; o_dcache_done pulses twice; o_dcache_we only on the read.
- Round-robin:
  - Stimulus: I-cache and D-cache read requests continuously high.
  - Required response: grants alternate I, D, I, D starting with I after reset.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; RD with no i_read_last_axi.
  - Required response: the owner's done pulses in the 8th RD cycle with no we, o_timeout_err=1 and stays high, next request still served.
- Completion/timeout coincidence:
  - Stimulus: TIMEOUT_CYCLES=8; i_read_last_axi in the 8th RD cycle.
  - Required response: we and done asserted, o_timeout_err remains 0.
- Reset mid-transaction:
  - Stimulus: arstn low during WR.
  - Required response: all outputs 0 asynchronously, no done pulse, and a request after reset release is granted normally.
